instr_issue_queue: RTL and testbench
====================================

# instr_issue_queue

Instruction buffer and issue stage directly upstream of the three-stage execute pipeline. Instructions are loaded into a circular FIFO, then issued one per cycle onto the pipeline's instruction input and write-enable strobe. Because the pipeline has no forwarding, the block inserts bubbles whenever the next instruction reads a register still being produced by an in-flight instruction.

## Interface
- DEPTH, 8, FIFO entries; power of two, at least 2
- PTR_W, 3, log2(DEPTH)
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-low
- load_valid  in  1  load_instr is presented this cycle
- load_instr  in  32  instruction to enqueue
- load_ready  out  1  FIFO can accept; equals !full
- start  in  1  one-cycle pulse; begin issuing
- halt  in  1  one-cycle pulse; stop issuing after the current cycle
- InstrOut  out  32  instruction to the pipeline's instruction input
- IssueEnable  out  1  drives the pipeline's WriteEnable; 1 means a real instruction
- count  out  PTR_W+1  current FIFO occupancy
- busy  out  1  state is RUN

## Operation
- Instruction fields used by the block:
  - rd = [25:21]
  - rs1 = [20:16]
  - rs2 = [15:11]
  - DataSrc = [26]; 1 means immediate, so rs2 is unused
- FIFO:
  - Read and write pointers of width PTR_W wrap modulo DEPTH; count tracks occupancy.
  - full = (count == DEPTH); empty = (count == 0).
  - An enqueue happens when load_valid && !full. It is accepted in any state.
  - When full, a load is refused even if a dequeue occurs in the same cycle.
  - Enqueue and dequeue in the same cycle leave count unchanged.
- In-flight scoreboard:
  - Three slots, slot0 (newest) to slot2. Each slot holds {v, rd}.
  - The slots shift every cycle. A bubble or an idle cycle shifts in v=0.
  - An issued instruction shifts in v=1, with rd taken from its rd field.
- Hazard:
  - The head instruction hazards if any slot with v=1 and rd != 0 has rd == rs1.
  - It also hazards if such a slot has rd == rs2 and DataSrc == 0.
- States:
  - IDLE:
    - No issue. Outputs InstrOut = 0, IssueEnable = 0.
    - Goes to RUN on start.
    - start while already in RUN is ignored.
  - RUN, each cycle:
    - If the FIFO is non-empty and there is no hazard: dequeue the head, register it onto InstrOut with IssueEnable = 1, and record it in slot0.
    - Otherwise issue a bubble: InstrOut = 0, IssueEnable = 0.
    - Goes to IDLE on halt. The cycle in which halt is sampled issues nothing.
    - An empty FIFO alone does not leave RUN; the block keeps issuing bubbles and resumes when data arrives.
- Simultaneous start and halt in IDLE: halt wins, and the state stays IDLE.
- Reset (asynchronous, mid-operation included):
  - State = IDLE; pointers and count = 0; all scoreboard v = 0.
  - InstrOut = 0, IssueEnable = 0, load_ready = 1, busy = 0.
  - FIFO contents are discarded.

## Timing
- InstrOut, IssueEnable and busy are registered outputs. load_ready and count reflect registered state.
- Latency from start to first issue:
  - start sampled at edge N, state RUN after N.
  - The head is issued at edge N+1, so IssueEnable is high after N+1.
- Enqueue-to-issue, with the FIFO empty and in RUN: the load is sampled at edge N, and the instruction appears on InstrOut after edge N+1.
- The hazard check uses the scoreboard state before the edge. A dependent instruction immediately after its producer therefore issues 3 cycles later: 3 bubbles.
- Dependency distances and the bubbles they cost:
  - Distance 2: 2 bubbles.
  - Distance 3: 1 bubble.
  - Distance 4 or more: no bubbles.
- Throughput is 1 instruction per cycle with no hazards.

## Test plan
- Reset mid-run:
  - Stimulus: load 4 instructions, start, then assert rst low during the 2nd issue.
  - Response: IssueEnable = 0, InstrOut = 0, count = 0 and busy = 0 immediately, without waiting for a clock edge.
  - After release, start issues nothing until new loads arrive.
- Independent stream:
  - Stimulus: load 5 instructions with distinct rd (1..5) and rs = 0, then start.
  - Response: IssueEnable is high for 5 consecutive cycles with InstrOut in load order, then bubbles; count goes 5 to 0.
- RAW distance 1:
  - Stimulus: first instruction has rd=3; the next has rs1=3.
  - Response: exactly 3 bubble cycles between the two issues.
  - Repeat with rs2=3 and DataSrc=1: 0 bubbles.
- Full FIFO:
  - Stimulus: load 8 instructions in IDLE, then a 9th with load_valid = 1.
  - Response: load_ready = 0, the 9th is dropped, and count stays 8.
  - After start, the 9th is accepted once the first dequeue has happened.
- Pointer wrap:
  - Stimulus: load and issue 20 instructions continuously with a load on every cycle.
  - Response: the issue order matches the load order across the wrap at entry 7 to 0, and count never exceeds 8.
- Halt and restart:
  - Stimulus: halt during a run with 3 instructions queued.
  - Response: no issue in the halt cycle; busy = 0 and count = 3.
  - A later start resumes with the next queued instruction, with no loss or duplication.

Source files
------------

// File: rtl/instr_issue_queue.sv
// Instruction buffer and in-order issue stage in front of a three-stage,
// forwarding-free execute pipeline. Instructions sit in a circular FIFO and are
// issued one per cycle. A three-deep in-flight scoreboard tracks the
// destination registers of recently issued instructions, and a bubble is
// inserted while the head instruction reads one of those registers.
//
//   state | meaning
//   IDLE  | no issue; outputs held at zero, loads still accepted
//   RUN   | issue the head each cycle unless the FIFO is empty or it hazards
module instr_issue_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [31:0]      load_instr,
  output logic             load_ready,
  input  logic             start,
  input  logic             halt,
  output logic [31:0]      InstrOut,
  output logic             IssueEnable,
  output logic [PTR_W:0]   count,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  state_e           state_q;
  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [2:0]       sb_v_q;
  logic [4:0]       sb_rd_q [3];
  logic [31:0]      instr_q;
  logic             issue_en_q;

  logic             full;
  logic             empty;
  logic             do_enq;
  logic             do_deq;
  logic             hazard;
  logic [4:0]       head_rd;
  logic [4:0]       head_rs1;
  logic [4:0]       head_rs2;
  logic             head_imm;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign head_rd  = mem_q[rd_ptr_q][25:21];
  assign head_rs1 = mem_q[rd_ptr_q][20:16];
  assign head_rs2 = mem_q[rd_ptr_q][15:11];
  assign head_imm = mem_q[rd_ptr_q][26];

  // A full FIFO refuses loads even if the head leaves in the same cycle.
  assign do_enq = load_valid && !full;
  assign do_deq = (state_q == RUN) && !halt && !empty && !hazard;

  // RAW check of the head against every live in-flight destination; r0 never hazards.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (sb_v_q[i] && (sb_rd_q[i] != 5'd0)) begin
        if (sb_rd_q[i] == head_rs1) hazard = 1'b1;
        if (!head_imm && (sb_rd_q[i] == head_rs2)) hazard = 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_enq) mem_q[wr_ptr_q] <= load_instr;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_enq) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_deq) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_enq, do_deq})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // In-flight scoreboard shifts every cycle; bubbles and idle cycles shift in v=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_v_q  <= '0;
      sb_rd_q <= '{default: '0};
    end else begin
      sb_v_q     <= {sb_v_q[1:0], do_deq};
      sb_rd_q[0] <= do_deq ? head_rd : 5'd0;
      sb_rd_q[1] <= sb_rd_q[0];
      sb_rd_q[2] <= sb_rd_q[1];
    end
  end

  // Control FSM with registered issue outputs; halt beats start in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      instr_q    <= '0;
      issue_en_q <= 1'b0;
    end else begin
      issue_en_q <= do_deq;
      instr_q    <= do_deq ? mem_q[rd_ptr_q] : 32'd0;
      case (state_q)
        IDLE:    if (start && !halt) state_q <= RUN;
        RUN:     if (halt) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign load_ready  = !full;
  assign count       = count_q;
  assign busy        = (state_q == RUN);
  assign InstrOut    = instr_q;
  assign IssueEnable = issue_en_q;

endmodule

// File: tb/tb_instr_issue_queue.sv
module tb_instr_issue_queue;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic [31:0] load_instr;
  logic        load_ready;
  logic        start;
  logic        halt;
  logic [31:0] InstrOut;
  logic        IssueEnable;
  logic [3:0]  count;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q [$];
  logic [31:0] got_i [$];
  int          got_c [$];

  instr_issue_queue #(.DEPTH(8), .PTR_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_instr (load_instr),
    .load_ready (load_ready),
    .start      (start),
    .halt       (halt),
    .InstrOut   (InstrOut),
    .IssueEnable(IssueEnable),
    .count      (count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic ds,
                                     input logic [10:0] tag);
    return {5'b10101, ds, rd, rs1, rs2, tag};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    load_valid = 1'b0;
    load_instr = '0;
    start = 1'b0;
    halt = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    tick();
  endtask

  // Load one instruction known to be accepted and record it as expected output.
  task automatic load(input logic [31:0] ins);
    load_valid = 1'b1;
    load_instr = ins;
    exp_q.push_back(ins);
    tick();
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Record which cycles issued and what; no checking here.
  task automatic collect(input int ncyc);
    got_i.delete();
    got_c.delete();
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (IssueEnable) begin
        got_i.push_back(InstrOut);
        got_c.push_back(i);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    load_valid = 1'b0;
    load_instr = '0;
    start = 1'b0;
    halt = 1'b0;
    #1 rst = 1'b0;
    #2;
    n_cmp++; if (IssueEnable !== 1'b0) begin n_bad++; $display("FAIL reset_ie got=%b exp=0", IssueEnable); end
    n_cmp++; if (InstrOut !== 32'd0) begin n_bad++; $display("FAIL reset_instr got=%h exp=0", InstrOut); end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (load_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", load_ready); end
    apply_reset();
  endtask

  task automatic test_independent();
    logic [31:0] e;
    apply_reset();
    for (int i = 1; i <= 5; i++) load(mk(5'(i), 5'd0, 5'd0, 1'b0, 11'(i)));
    n_cmp++; if (count !== 4'd5) begin n_bad++; $display("FAIL indep_count_loaded got=%0d exp=5", count); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL indep_busy got=%b exp=1", busy); end
    n_cmp++; if (IssueEnable !== 1'b0) begin n_bad++; $display("FAIL indep_first_cycle_ie got=%b exp=0", IssueEnable); end
    collect(10);
    n_cmp++; if (got_i.size() != 5) begin n_bad++; $display("FAIL indep_issue_count got=%0d exp=5", got_i.size()); end
    for (int k = 0; k < got_i.size(); k++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      n_cmp++; if (got_i[k] !== e) begin n_bad++; $display("FAIL indep_instr[%0d] got=%h exp=%h", k, got_i[k], e); end
      n_cmp++; if (got_c[k] != k) begin n_bad++; $display("FAIL indep_cycle[%0d] got=%0d exp=%0d", k, got_c[k], k); end
    end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL indep_count_end got=%0d exp=0", count); end
  endtask

  task automatic test_raw();
    logic [31:0] seq [5];
    int          cyc [5];
    int          n;
    logic [31:0] e;
    for (int s = 0; s < 6; s++) begin
      logic [10:0] t;
      logic [31:0] a, x, y, z;
      t = 11'(s * 16);
      a = mk(5'd3, 5'd0, 5'd0, 1'b0, t);
      x = mk(5'd5, 5'd0, 5'd0, 1'b0, t + 11'd1);
      y = mk(5'd6, 5'd0, 5'd0, 1'b0, t + 11'd2);
      z = mk(5'd7, 5'd0, 5'd0, 1'b0, t + 11'd3);
      n = 2;
      seq[0] = a; cyc[0] = 0;
      case (s)
        0: begin seq[1] = mk(5'd4, 5'd3, 5'd0, 1'b0, t + 11'd4); cyc[1] = 4; end
        1: begin seq[1] = mk(5'd4, 5'd0, 5'd3, 1'b1, t + 11'd4); cyc[1] = 1; end
        2: begin seq[1] = mk(5'd4, 5'd0, 5'd3, 1'b0, t + 11'd4); cyc[1] = 4; end
        3: begin
          n = 3;
          seq[1] = x; cyc[1] = 1;
          seq[2] = mk(5'd4, 5'd3, 5'd0, 1'b0, t + 11'd4); cyc[2] = 4;
        end
        4: begin
          n = 4;
          seq[1] = x; cyc[1] = 1;
          seq[2] = y; cyc[2] = 2;
          seq[3] = mk(5'd4, 5'd3, 5'd0, 1'b0, t + 11'd4); cyc[3] = 4;
        end
        default: begin
          n = 5;
          seq[1] = x; cyc[1] = 1;
          seq[2] = y; cyc[2] = 2;
          seq[3] = z; cyc[3] = 3;
          seq[4] = mk(5'd4, 5'd3, 5'd0, 1'b0, t + 11'd4); cyc[4] = 4;
        end
      endcase
      apply_reset();
      for (int i = 0; i < n; i++) load(seq[i]);
      pulse_start();
      collect(12);
      n_cmp++; if (got_i.size() != n) begin n_bad++; $display("FAIL raw%0d_issue_count got=%0d exp=%0d", s, got_i.size(), n); end
      for (int k = 0; k < got_i.size(); k++) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_cmp++; if (got_i[k] !== e) begin n_bad++; $display("FAIL raw%0d_instr[%0d] got=%h exp=%h", s, k, got_i[k], e); end
        if (k < n) begin
          n_cmp++; if (got_c[k] != cyc[k]) begin n_bad++; $display("FAIL raw%0d_cycle[%0d] got=%0d exp=%0d", s, k, got_c[k], cyc[k]); end
        end
      end
    end
  endtask

  task automatic test_full();
    logic [31:0] ninth;
    logic [31:0] e;
    apply_reset();
    for (int i = 0; i < 8; i++) load(mk(5'(i + 8), 5'd0, 5'd0, 1'b0, 11'(100 + i)));
    n_cmp++; if (load_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got=%b exp=0", load_ready); end
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL full_count got=%0d exp=8", count); end
    ninth = mk(5'd20, 5'd0, 5'd0, 1'b0, 11'd200);
    load_valid = 1'b1;
    load_instr = ninth;
    tick();
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL full_drop_count got=%0d exp=8", count); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL full_start_count got=%0d exp=8", count); end
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (IssueEnable !== 1'b1 || InstrOut !== e) begin n_bad++; $display("FAIL full_first_issue got=%b/%h exp=1/%h", IssueEnable, InstrOut, e); end
    n_cmp++; if (count !== 4'd7) begin n_bad++; $display("FAIL full_refused_with_deq got=%0d exp=7", count); end
    exp_q.push_back(ninth);
    tick();
    load_valid = 1'b0;
    e = exp_q.pop_front();
    n_cmp++; if (IssueEnable !== 1'b1 || InstrOut !== e) begin n_bad++; $display("FAIL full_second_issue got=%b/%h exp=1/%h", IssueEnable, InstrOut, e); end
    n_cmp++; if (count !== 4'd7) begin n_bad++; $display("FAIL full_enq_deq_count got=%0d exp=7", count); end
    collect(12);
    n_cmp++; if (got_i.size() != 7) begin n_bad++; $display("FAIL full_rest_count got=%0d exp=7", got_i.size()); end
    for (int k = 0; k < got_i.size(); k++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      n_cmp++; if (got_i[k] !== e) begin n_bad++; $display("FAIL full_instr[%0d] got=%h exp=%h", k, got_i[k], e); end
    end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL full_end_count got=%0d exp=0", count); end
  endtask

  task automatic test_wrap();
    logic [31:0] ins;
    logic [31:0] e;
    int          issued;
    apply_reset();
    pulse_start();
    got_i.delete();
    for (int i = 0; i < 24; i++) begin
      if (i < 20) begin
        ins = mk(5'($urandom_range(1, 31)), 5'd0, 5'd0, 1'($urandom_range(0, 1)), 11'(300 + i));
        load_valid = 1'b1;
        load_instr = ins;
        exp_q.push_back(ins);
      end else begin
        load_valid = 1'b0;
      end
      tick();
      if (IssueEnable) got_i.push_back(InstrOut);
      n_cmp++; if (count > 4'd8) begin n_bad++; $display("FAIL wrap_count_bound got=%0d exp<=8", count); end
    end
    load_valid = 1'b0;
    issued = got_i.size();
    n_cmp++; if (issued != 20) begin n_bad++; $display("FAIL wrap_issue_count got=%0d exp=20", issued); end
    for (int k = 0; k < issued; k++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      n_cmp++; if (got_i[k] !== e) begin n_bad++; $display("FAIL wrap_instr[%0d] got=%h exp=%h", k, got_i[k], e); end
    end
  endtask

  task automatic test_halt();
    logic [31:0] e;
    apply_reset();
    for (int i = 0; i < 6; i++) load(mk(5'(i + 1), 5'd0, 5'd0, 1'b0, 11'(400 + i)));
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (IssueEnable !== 1'b1 || InstrOut !== e) begin n_bad++; $display("FAIL halt_pre_issue[%0d] got=%b/%h exp=1/%h", k, IssueEnable, InstrOut, e); end
    end
    halt = 1'b1;
    tick();
    halt = 1'b0;
    n_cmp++; if (IssueEnable !== 1'b0) begin n_bad++; $display("FAIL halt_cycle_ie got=%b exp=0", IssueEnable); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL halt_busy got=%b exp=0", busy); end
    n_cmp++; if (count !== 4'd3) begin n_bad++; $display("FAIL halt_count got=%0d exp=3", count); end
    tick();
    tick();
    n_cmp++; if (IssueEnable !== 1'b0 || count !== 4'd3) begin n_bad++; $display("FAIL halt_idle got=%b/%0d exp=0/3", IssueEnable, count); end
    start = 1'b1;
    halt = 1'b1;
    tick();
    start = 1'b0;
    halt = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL halt_wins_busy got=%b exp=0", busy); end
    pulse_start();
    collect(8);
    n_cmp++; if (got_i.size() != 3) begin n_bad++; $display("FAIL halt_resume_count got=%0d exp=3", got_i.size()); end
    for (int k = 0; k < got_i.size(); k++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      n_cmp++; if (got_i[k] !== e) begin n_bad++; $display("FAIL halt_resume_instr[%0d] got=%h exp=%h", k, got_i[k], e); end
      n_cmp++; if (got_c[k] != k) begin n_bad++; $display("FAIL halt_resume_cycle[%0d] got=%0d exp=%0d", k, got_c[k], k); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    logic [31:0] late;
    apply_reset();
    for (int i = 0; i < 4; i++) load(mk(5'(i + 1), 5'd0, 5'd0, 1'b0, 11'(500 + i)));
    pulse_start();
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (IssueEnable !== 1'b1 || InstrOut !== e) begin n_bad++; $display("FAIL rstmid_issue1 got=%b/%h exp=1/%h", IssueEnable, InstrOut, e); end
    tick();
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (IssueEnable !== 1'b0) begin n_bad++; $display("FAIL rstmid_ie got=%b exp=0", IssueEnable); end
    n_cmp++; if (InstrOut !== 32'd0) begin n_bad++; $display("FAIL rstmid_instr got=%h exp=0", InstrOut); end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL rstmid_count got=%0d exp=0", count); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    exp_q.delete();
    #3 rst = 1'b1;
    tick();
    pulse_start();
    collect(5);
    n_cmp++; if (got_i.size() != 0) begin n_bad++; $display("FAIL rstmid_no_issue got=%0d exp=0", got_i.size()); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_restart_busy got=%b exp=1", busy); end
    late = mk(5'd9, 5'd0, 5'd0, 1'b0, 11'd600);
    load(late);
    n_cmp++; if (IssueEnable !== 1'b0) begin n_bad++; $display("FAIL rstmid_latency_early got=%b exp=0", IssueEnable); end
    tick();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    n_cmp++; if (IssueEnable !== 1'b1 || InstrOut !== e) begin n_bad++; $display("FAIL rstmid_late_issue got=%b/%h exp=1/%h", IssueEnable, InstrOut, e); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_independent();
    test_raw();
    test_full();
    test_wrap();
    test_halt();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
